accum_xcel_launcher: RTL and testbench

- Processor-side command/status front end for the accumulator accelerator.
- Sits directly upstream of the accelerator. It takes register writes and reads from the TinyRV1 processor, holds the element count, and issues a single-cycle go pulse.
- It captures the accelerator's result on result_val and exposes busy, done and error status for polling.
- It does not touch the accelerator's memory port.

---
 rtl/accum_xcel_launcher_pkg.sv | 21 ++
 rtl/accum_xcel_launcher_ctrl.sv | 83 ++++++++
 rtl/accum_xcel_launcher.sv | 105 ++++++++++
 tb/tb_accum_xcel_launcher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_xcel_launcher_pkg.sv
// Shared types and register map for the accumulator accelerator launcher.
package accum_xcel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam logic [2:0] ADDR_SIZE   = 3'd0;
  localparam logic [2:0] ADDR_GO     = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_CYCLES = 3'd4;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;
  localparam int ERR_BIT  = 2;

endpackage

// File: rtl/accum_xcel_launcher_ctrl.sv
// Launch FSM: sequences IDLE/START/BUSY/DONE and owns go, busy, done and sticky err.
module accum_xcel_launcher_ctrl
  import accum_xcel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go_wr,
  input  logic size_wr,
  input  logic err_clr,
  input  logic size_zero,
  input  logic result_val,
  output logic go,
  output logic busy,
  output logic done,
  output logic err,
  output logic launch,
  output logic zero_launch,
  output logic capture
);

  state_e state_q, state_d;
  logic   go_q, go_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    launch      = 1'b0;
    zero_launch = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_wr) begin
          if (size_zero) begin
            state_d     = ST_DONE;
            zero_launch = 1'b1;
          end else begin
            state_d = ST_START;
            launch  = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_BUSY;
      ST_BUSY: begin
        if (result_val) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Command writes that would disturb a running job are dropped and flagged.
    if (busy_q && (go_wr || size_wr)) err_d = 1'b1;
    if (err_clr)                      err_d = 1'b0;
    go_d   = (state_d == ST_START);
    busy_d = (state_d == ST_START) || (state_d == ST_BUSY);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign go   = go_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: rtl/accum_xcel_launcher.sv
// Processor-facing command/status registers for the accumulator accelerator.
// Optional run-cycle counter at address 4 enabled by ACCUM_XCEL_LAUNCHER_CYCLES_EN.
module accum_xcel_launcher
  import accum_xcel_pkg::*;
#(
  parameter int SIZE_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_wen,
  input  logic [2:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic              go,
  output logic [SIZE_W-1:0] size,
  input  logic              result_val,
  input  logic [DATA_W-1:0] result
);

  logic [SIZE_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              go_wr, size_wr, err_clr;
  logic              busy, done, err, launch, zero_launch, capture;
  logic              unused_wdata;

  assign go_wr        = cmd_wen && (cmd_addr == ADDR_GO);
  assign size_wr      = cmd_wen && (cmd_addr == ADDR_SIZE);
  assign err_clr      = cmd_wen && (cmd_addr == ADDR_STATUS) && cmd_wdata[ERR_BIT];
  assign unused_wdata = ^cmd_wdata;

  accum_xcel_launcher_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .go_wr       (go_wr),
    .size_wr     (size_wr),
    .err_clr     (err_clr),
    .size_zero   (size_q == '0),
    .result_val  (result_val),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .launch      (launch),
    .zero_launch (zero_launch),
    .capture     (capture)
  );

  always_comb begin
    size_d = size_q;
    if (size_wr && !busy) size_d = cmd_wdata[SIZE_W-1:0];
    result_d = result_q;
    if (capture)          result_d = result;
    else if (zero_launch) result_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q   <= '0;
      result_q <= '0;
    end else begin
      size_q   <= size_d;
      result_q <= result_d;
    end
  end

`ifdef ACCUM_XCEL_LAUNCHER_CYCLES_EN
  logic [31:0] cycles_q, cycles_d;

  // Counts START plus every BUSY cycle of the current job, saturating.
  always_comb begin
    cycles_d = cycles_q;
    if (launch)                       cycles_d = '0;
    else if (busy && cycles_q != '1)  cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end
`else
  logic [31:0] cycles_q;
  logic        unused_launch;
  assign cycles_q      = '0;
  assign unused_launch = launch;
`endif

  always_comb begin
    cmd_rdata = '0;
    case (cmd_addr)
      ADDR_SIZE:   cmd_rdata = DATA_W'(size_q);
      ADDR_STATUS: begin
        cmd_rdata[BUSY_BIT] = busy;
        cmd_rdata[DONE_BIT] = done;
        cmd_rdata[ERR_BIT]  = err;
      end
      ADDR_RESULT: cmd_rdata = result_q;
      ADDR_CYCLES: cmd_rdata = DATA_W'(cycles_q);
      default:     cmd_rdata = '0;
    endcase
  end

  assign size = size_q;

endmodule

// File: tb/tb_accum_xcel_launcher.sv
// Self-checking bench for accum_xcel_launcher: directed scenarios plus randomized jobs.
module tb_accum_xcel_launcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_wen;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_rdata;
  logic        go;
  logic [13:0] size;
  logic        result_val;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;
  int go_count = 0;

  accum_xcel_launcher dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_wen    (cmd_wen),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_rdata  (cmd_rdata),
    .go         (go),
    .size       (size),
    .result_val (result_val),
    .result     (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (go === 1'b1) go_count++;

  initial begin
    #2_000_000;
    $display("FAIL timeout n_total=%0d", n_total);
    $fatal(1);
  end

  function automatic logic [31:0] exp_cycles(input int c);
`ifdef ACCUM_XCEL_LAUNCHER_CYCLES_EN
    return 32'(c);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cmd_wen = 1'b1; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cmd_addr = a;
    #1;
    d = cmd_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; cmd_wen = 0; cmd_addr = 0; cmd_wdata = 0; result_val = 0; result = 0;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (go !== 1'b0) $display("FAIL reset_go got=%b exp=0", go); else n_pass++;
    n_total++; if (size !== 14'd0) $display("FAIL reset_size got=%h exp=0", size); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd0) $display("FAIL reset_status got=%h exp=0", v); else n_pass++;
    rd(3'd3, v);
    n_total++; if (v !== 32'd0) $display("FAIL reset_result got=%h exp=0", v); else n_pass++;
    rd(3'd0, v);
    n_total++; if (v !== 32'd0) $display("FAIL reset_size_rd got=%h exp=0", v); else n_pass++;
    for (int a = 4; a < 8; a++) begin
      rd(3'(a), v);
      n_total++; if (v !== 32'd0) $display("FAIL reset_addr%0d got=%h exp=0", a, v); else n_pass++;
    end
  endtask

  task automatic test_launch();
    logic [31:0] v;
    int t0;
    // Write and read SIZE in the same cycle: read sees the old value.
    cmd_wen = 1'b1; cmd_addr = 3'd0; cmd_wdata = 32'hFFFF_0008;
    #1;
    n_total++; if (cmd_rdata !== 32'd0) $display("FAIL rw_same_cycle got=%h exp=0", cmd_rdata); else n_pass++;
    tick();
    cmd_wen = 1'b0;
    rd(3'd0, v);
    n_total++; if (v !== 32'd8) $display("FAIL size_rd got=%h exp=8", v); else n_pass++;
    t0 = go_count;
    wr(3'd1, 32'd0);  // cycle N; now in N+1
    n_total++; if (go !== 1'b1) $display("FAIL launch_go_n1 got=%b exp=1", go); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd1) $display("FAIL launch_status_n1 got=%h exp=1", v); else n_pass++;
    rd(3'd1, v);
    n_total++; if (v !== 32'd0) $display("FAIL go_reg_rd got=%h exp=0", v); else n_pass++;
    tick();           // N+2
    n_total++; if (go !== 1'b0) $display("FAIL launch_go_n2 got=%b exp=0", go); else n_pass++;
    for (int i = 0; i < 8; i++) tick();  // N+10
    result_val = 1'b1; result = 32'h0000_0024;
    tick();           // N+11
    result_val = 1'b0;
    rd(3'd2, v);
    n_total++; if (v !== 32'd2) $display("FAIL launch_status_done got=%h exp=2", v); else n_pass++;
    rd(3'd3, v);
    n_total++; if (v !== 32'h24) $display("FAIL launch_result got=%h exp=24", v); else n_pass++;
    n_total++; if (go_count - t0 !== 1) $display("FAIL launch_go_pulses got=%0d exp=1", go_count - t0); else n_pass++;
    rd(3'd4, v);
    n_total++; if (v !== exp_cycles(10)) $display("FAIL launch_cycles got=%h exp=%h", v, exp_cycles(10)); else n_pass++;
  endtask

  task automatic test_zero_size();
    logic [31:0] v;
    int t0;
    wr(3'd0, 32'd0);
    t0 = go_count;
    wr(3'd1, 32'h1);
    n_total++; if (go !== 1'b0) $display("FAIL zero_go got=%b exp=0", go); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd2) $display("FAIL zero_status got=%h exp=2", v); else n_pass++;
    rd(3'd3, v);
    n_total++; if (v !== 32'd0) $display("FAIL zero_result got=%h exp=0", v); else n_pass++;
    tick(); tick();
    n_total++; if (go_count !== t0) $display("FAIL zero_go_pulses got=%0d exp=%0d", go_count, t0); else n_pass++;
  endtask

  task automatic test_busy_writes();
    logic [31:0] v;
    int t0;
    wr(3'd0, 32'd8);
    t0 = go_count;
    wr(3'd1, 32'd0);
    tick();
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd0);
    tick();
    n_total++; if (size !== 14'd8) $display("FAIL busy_size_out got=%h exp=8", size); else n_pass++;
    rd(3'd0, v);
    n_total++; if (v !== 32'd8) $display("FAIL busy_size_rd got=%h exp=8", v); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd5) $display("FAIL busy_status_err got=%h exp=5", v); else n_pass++;
    n_total++; if (go_count - t0 !== 1) $display("FAIL busy_go_pulses got=%0d exp=1", go_count - t0); else n_pass++;
    wr(3'd2, 32'd4);
    rd(3'd2, v);
    n_total++; if (v !== 32'd1) $display("FAIL busy_err_clear got=%h exp=1", v); else n_pass++;
    result_val = 1'b1; result = 32'h11;
    tick();
    result_val = 1'b0;
    rd(3'd3, v);
    n_total++; if (v !== 32'h11) $display("FAIL busy_result got=%h exp=11", v); else n_pass++;
  endtask

  task automatic test_reset_busy();
    logic [31:0] v;
    wr(3'd0, 32'd8);
    wr(3'd1, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (go !== 1'b0) $display("FAIL rstbusy_go got=%b exp=0", go); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd0) $display("FAIL rstbusy_status got=%h exp=0", v); else n_pass++;
    rd(3'd3, v);
    n_total++; if (v !== 32'd0) $display("FAIL rstbusy_result got=%h exp=0", v); else n_pass++;
    rd(3'd0, v);
    n_total++; if (v !== 32'd0) $display("FAIL rstbusy_size got=%h exp=0", v); else n_pass++;
    tick(); tick();
    n_total++; if (go !== 1'b0) $display("FAIL rstbusy_go_later got=%b exp=0", go); else n_pass++;
  endtask

  task automatic test_idle_result();
    logic [31:0] v;
    result_val = 1'b1; result = 32'h0000_DEAD;
    tick();
    result_val = 1'b0;
    rd(3'd3, v);
    n_total++; if (v !== 32'd0) $display("FAIL idle_result got=%h exp=0", v); else n_pass++;
    rd(3'd2, v);
    n_total++; if (v !== 32'd0) $display("FAIL idle_status got=%h exp=0", v); else n_pass++;
  endtask

  // Randomized jobs against a job-level model: what was launched, what came back,
  // whether any disallowed write happened, and how long the job ran.
  task automatic test_random();
    logic [31:0] v, d, res;
    logic [13:0] sz;
    logic        m_err = 1'b0;
    logic [31:0] m_result = 32'd0;
    int          m_cycles = 0;
    int          lat, t0;
    for (int it = 0; it < 24; it++) begin
      sz  = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      lat = (it == 0) ? 6 : int'($urandom_range(1, 10));
      res = $urandom;
      d = $urandom; d[13:0] = sz;
      wr(3'd0, d);
      t0 = go_count;
      wr(3'd1, $urandom);
      if (sz == 14'd0) begin
        m_result = 32'd0;
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          wr(3'd1, $urandom);
          m_err = 1'b1;
        end else begin
          result_val = 1'($urandom_range(0, 1)); result = $urandom;
          tick();
          result_val = 1'b0;
        end
        for (int k = 1; k < lat; k++) begin
          case ($urandom_range(0, 3))
            0: begin wr(3'd0, $urandom); m_err = 1'b1; end
            1: begin wr(3'd1, $urandom); m_err = 1'b1; end
            default: tick();
          endcase
        end
        result_val = 1'b1; result = res;
        tick();
        result_val = 1'b0;
        m_result = res;
        m_cycles = lat + 1;
      end
      rd(3'd2, v);
      n_total++; if (v !== {29'd0, m_err, 2'b10}) $display("FAIL rnd%0d_status got=%h exp=%h", it, v, {29'd0, m_err, 2'b10}); else n_pass++;
      rd(3'd3, v);
      n_total++; if (v !== m_result) $display("FAIL rnd%0d_result got=%h exp=%h", it, v, m_result); else n_pass++;
      n_total++; if (size !== sz) $display("FAIL rnd%0d_size got=%h exp=%h", it, size, sz); else n_pass++;
      n_total++; if (go_count - t0 !== ((sz == 0) ? 0 : 1)) $display("FAIL rnd%0d_go_pulses got=%0d exp=%0d", it, go_count - t0, (sz == 0) ? 0 : 1); else n_pass++;
      rd(3'd4, v);
      n_total++; if (v !== exp_cycles(m_cycles)) $display("FAIL rnd%0d_cycles got=%h exp=%h", it, v, exp_cycles(m_cycles)); else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        wr(3'd2, $urandom | 32'h4);
        m_err = 1'b0;
      end else begin
        wr(3'd2, $urandom & ~32'h4);
      end
      result_val = 1'b1; result = $urandom;
      tick();
      result_val = 1'b0;
      rd(3'd2, v);
      n_total++; if (v !== {29'd0, m_err, 2'b10}) $display("FAIL rnd%0d_status_post got=%h exp=%h", it, v, {29'd0, m_err, 2'b10}); else n_pass++;
      rd(3'd3, v);
      n_total++; if (v !== m_result) $display("FAIL rnd%0d_result_hold got=%h exp=%h", it, v, m_result); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_zero_size();
    test_busy_writes();
    test_reset_busy();
    test_idle_result();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
